// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - character screen memory with terminal-style cursor writes and beam-aligned readout
module text_buffer #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 30,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  input  logic [7:0]                wr_char,
  output logic                      wr_ready,
  input  logic                      clear,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic                      video_on,
  output logic [7:0]                char_out,
  output logic [9:0]                x_out,
  output logic [9:0]                y_out,
  output logic                      video_on_out,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_ptr;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_mem [0:CELLS-1];

  logic            w_accept;
  logic            w_printable;
  logic [AW-1:0]   w_row_base;
  logic [AW-1:0]   w_cur_addr;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [7:0]      w_wdata;
  logic [RW-1:0]   w_next_row;
  logic [6:0]      w_rd_col;
  logic [4:0]      w_rd_row;
  logic [AW-1:0]   w_rd_addr;
  logic            w_rd_in;

  assign wr_ready    = (r_state == IDLE) && !clear;
  assign w_accept    = wr_valid && wr_ready && !reset;
  assign w_printable = (wr_char >= 8'h20) && (wr_char <= 8'h7E);
  assign w_row_base  = AW'(r_row) * AW'(COLS);
  assign w_cur_addr  = w_row_base + AW'(r_col);
  assign w_next_row  = (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
  assign cursor_col  = r_col;
  assign cursor_row  = r_row;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = FILL_CHAR;
    case (r_state)
      CLR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_ptr;
      end
      CLR_ROW: begin
        w_we    = 1'b1;
        w_waddr = w_row_base + r_ptr;
      end
      default: begin
        if (w_accept && w_printable) begin
          w_we    = 1'b1;
          w_waddr = w_cur_addr;
          w_wdata = wr_char;
        end else if (w_accept && wr_char == 8'h08 && r_col != '0) begin
          w_we    = 1'b1;
          w_waddr = w_cur_addr - 1'b1;
        end
      end
    endcase
  end

  // clear has priority over every state and discards a coincident write
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state <= CLR_ALL;
      r_ptr   <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        CLR_ALL: begin
          if (r_ptr == AW'(CELLS - 1)) begin
            r_state <= IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        CLR_ROW: begin
          if (r_ptr == AW'(COLS - 1)) begin
            r_state <= IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            if (w_printable) begin
              if (r_col < CW'(COLS - 1)) begin
                r_col <= r_col + 1'b1;
              end else begin
                r_col   <= '0;
                r_row   <= w_next_row;
                r_state <= CLR_ROW;
                r_ptr   <= '0;
              end
            end else if (wr_char == 8'h0A) begin
              r_col   <= '0;
              r_row   <= w_next_row;
              r_state <= CLR_ROW;
              r_ptr   <= '0;
            end else if (wr_char == 8'h0D) begin
              r_col <= '0;
            end else if (wr_char == 8'h08 && r_col != '0) begin
              r_col <= r_col - 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign w_rd_col  = x[9:3];
  assign w_rd_row  = y[8:4];
  assign w_rd_in   = video_on && (int'(w_rd_col) < COLS) && (int'(w_rd_row) < ROWS);
  assign w_rd_addr = AW'(w_rd_row) * AW'(COLS) + AW'(w_rd_col);

  // out-of-area addresses may alias real cells; the fill mux hides them
  always_ff @(posedge clk) begin
    if (reset) begin
      char_out     <= 8'h00;
      x_out        <= '0;
      y_out        <= '0;
      video_on_out <= 1'b0;
    end else begin
      char_out     <= w_rd_in ? r_mem[w_rd_addr] : FILL_CHAR;
      x_out        <= x;
      y_out        <= y;
      video_on_out <= video_on;
    end
  end

endmodule

// File: tb/tb_text_buffer.sv
// tb/tb_text_buffer.sv - directed self-checking bench for text_buffer
module tb_text_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;
  logic       clear;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic [7:0] char_out;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic       video_on_out;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  int n_cmp = 0;
  int n_err = 0;

  text_buffer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
    .clear(clear), .x(x), .y(y), .video_on(video_on), .char_out(char_out), .x_out(x_out),
    .y_out(y_out), .video_on_out(video_on_out), .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int lim, output int n);
    n = 0;
    while (!wr_ready && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    wr_char  = c;
    wr_valid = 1'b1;
    wait_ready(5000, n);
    chk("send_ready", {31'b0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int c, input int r, output logic [7:0] d);
    x        = 10'(c * 8);
    y        = 10'(r * 16);
    video_on = 1'b1;
    tick();
    d = char_out;
  endtask

  task automatic count_not_fill(input int r0, input int r1, output int bad);
    logic [7:0] d;
    bad = 0;
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < 80; c++) begin
        rd(c, r, d);
        if (d !== 8'h20) bad++;
      end
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0] d;

    reset = 1'b1; wr_valid = 1'b0; wr_char = 8'h00; clear = 1'b0;
    x = 10'd16; y = 10'd32; video_on = 1'b1;
    tick();
    tick();
    chk("rst_char_out", {24'b0, char_out}, 32'h00);
    chk("rst_x_out", {22'b0, x_out}, 32'd0);
    chk("rst_von_out", {31'b0, video_on_out}, 32'd0);
    chk("rst_cursor", {20'b0, cursor_row, cursor_col}, 32'd0);
    chk("rst_ready", {31'b0, wr_ready}, 32'd0);

    reset = 1'b0; wr_valid = 1'b1; wr_char = 8'h07;
    wait_ready(3000, n);
    wr_valid = 1'b0;
    chk("clr_all_len", n, 32'd2400);
    count_not_fill(0, 29, bad);
    chk("post_reset_fill", bad, 32'd0);

    send(8'h41);
    send(8'h42);
    chk("ab_col", {25'b0, cursor_col}, 32'd2);
    chk("ab_row", {27'b0, cursor_row}, 32'd0);
    x = 10'd8; y = 10'd0; video_on = 1'b1;
    tick();
    chk("rd_b", {24'b0, char_out}, 32'h42);
    chk("rd_b_xout", {22'b0, x_out}, 32'd8);
    chk("rd_b_yout", {22'b0, y_out}, 32'd0);
    chk("rd_b_von", {31'b0, video_on_out}, 32'd1);
    x = 10'd640;
    tick();
    chk("rd_x640", {24'b0, char_out}, 32'h20);
    x = 10'd0; video_on = 1'b0;
    tick();
    chk("rd_von0", {24'b0, char_out}, 32'h20);
    chk("rd_von0_out", {31'b0, video_on_out}, 32'd0);

    send(8'h08);
    chk("bs1_col", {25'b0, cursor_col}, 32'd1);
    rd(1, 0, d);
    chk("bs1_cell1", {24'b0, d}, 32'h20);
    rd(0, 0, d);
    chk("bs1_cell0", {24'b0, d}, 32'h41);
    send(8'h08);
    send(8'h08);
    send(8'h08);
    chk("bs_floor_col", {25'b0, cursor_col}, 32'd0);
    rd(0, 0, d);
    chk("bs_cell0", {24'b0, d}, 32'h20);

    send(8'h48); send(8'h45); send(8'h4C); send(8'h4C); send(8'h4F);
    chk("hello_col", {25'b0, cursor_col}, 32'd5);
    send(8'h0D);
    chk("cr_col", {25'b0, cursor_col}, 32'd0);
    chk("cr_row", {27'b0, cursor_row}, 32'd0);
    rd(0, 0, d);
    chk("cr_cell0", {24'b0, d}, 32'h48);
    rd(4, 0, d);
    chk("cr_cell4", {24'b0, d}, 32'h4F);
    rd(5, 0, d);
    chk("cr_cell5", {24'b0, d}, 32'h20);

    for (int i = 0; i < 80; i++) send(8'h21 + 8'(i));
    chk("wrap_col", {25'b0, cursor_col}, 32'd0);
    chk("wrap_row", {27'b0, cursor_row}, 32'd1);
    wait_ready(200, n);
    chk("clr_row_len", n, 32'd80);
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      rd(c, 0, d);
      if (d !== 8'h21 + 8'(c)) bad++;
    end
    chk("row0_intact", bad, 32'd0);

    for (int i = 0; i < 27; i++) send(8'h0A);
    chk("lf_row28", {27'b0, cursor_row}, 32'd28);
    send(8'h51);
    send(8'h0A);
    chk("lf_row29", {27'b0, cursor_row}, 32'd29);
    send(8'h0A);
    chk("lf_wrap_row", {27'b0, cursor_row}, 32'd0);
    chk("lf_wrap_col", {25'b0, cursor_col}, 32'd0);
    wait_ready(200, n);
    chk("lf_clr_len", n, 32'd80);
    count_not_fill(0, 0, bad);
    chk("row0_cleared", bad, 32'd0);
    rd(0, 28, d);
    chk("row28_kept", {24'b0, d}, 32'h51);

    send(8'h4D);
    send(8'h0A);
    for (int i = 0; i < 10; i++) tick();
    clear = 1'b1; wr_valid = 1'b1; wr_char = 8'h5A;
    chk("clear_blocks_ready", {31'b0, wr_ready}, 32'd0);
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    chk("clear_cursor", {20'b0, cursor_row, cursor_col}, 32'd0);
    wait_ready(3000, n);
    chk("clear_len", n, 32'd2400);
    count_not_fill(0, 29, bad);
    chk("clear_fill", bad, 32'd0);

    send(8'h0A);
    for (int i = 0; i < 5; i++) tick();
    x = 10'd16; video_on = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_cursor", {20'b0, cursor_row, cursor_col}, 32'd0);
    chk("midrst_char", {24'b0, char_out}, 32'h00);
    chk("midrst_xout", {22'b0, x_out}, 32'd0);
    chk("midrst_ready", {31'b0, wr_ready}, 32'd0);
    wait_ready(3000, n);
    chk("midrst_len", n, 32'd2400);

    x = 10'd0; y = 10'd0; video_on = 1'b1;
    wr_char = 8'h4B; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("rw_same_old", {24'b0, char_out}, 32'h20);
    tick();
    chk("rw_same_new", {24'b0, char_out}, 32'h4B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
